// File: rtl/masked_pixel_fill.sv
// Replaces all-ones (defective) pixels with an interpolation of their horizontal
// neighbours on the same line; AXI4-Stream in/out with per-frame fill statistics.
module masked_pixel_fill #(
    parameter int unsigned   DW       = 16,
    parameter logic [DW-1:0] FILL_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic          s_tlast,
    input  logic          s_tuser,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic          m_tuser,
    output logic [15:0]   frame_fill_count,
    output logic          frame_done
);

    localparam int unsigned   CW      = 16;
    localparam int unsigned   SW      = DW + 1;
    localparam logic [DW-1:0] MASK    = '1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] l_q;
    logic          lv_q;
    logic [DW-1:0] c_q;
    logic          c_last_q;
    logic          c_user_q;
    logic [CW-1:0] fill_cnt_q;

    logic          adv;
    logic          early_sof;
    logic          accept;
    logic          emit;
    logic          hit;
    logic          l_ok;
    logic          r_ok;
    logic [SW-1:0] sum;
    logic [DW-1:0] fill_data;
    logic [CW-1:0] cnt_inc;

    // Handshake decode and replacement of the centre pixel.
    always_comb begin
        adv       = !m_tvalid || m_tready;
        early_sof = (state == HOLD) && s_tvalid && s_tuser;
        s_tready  = 1'b0;
        if (!rst) begin
            case (state)
                EMPTY:   s_tready = adv;
                HOLD:    s_tready = adv && !early_sof;
                default: s_tready = 1'b0;
            endcase
        end
        accept = s_tvalid && s_tready;
        emit   = ((state == HOLD) && accept) || ((state == FLUSH) && adv);
        hit    = enable && (c_q == MASK);

        // Right neighbour exists only when emitting from HOLD on an accepted beat.
        l_ok = lv_q && (l_q != MASK);
        r_ok = (state == HOLD) && (s_tdata != MASK);
        sum  = SW'(l_q) + SW'(s_tdata);

        fill_data = c_q;
        if (hit) begin
            if (l_ok && r_ok) begin
                fill_data = sum[SW-1:1];
            end else if (l_ok) begin
                fill_data = l_q;
            end else if (r_ok) begin
                fill_data = s_tdata;
            end else begin
                fill_data = FILL_VAL;
            end
        end

        cnt_inc = (fill_cnt_q == CNT_MAX) ? fill_cnt_q : fill_cnt_q + CW'(hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= EMPTY;
            l_q              <= '0;
            lv_q             <= 1'b0;
            c_q              <= '0;
            c_last_q         <= 1'b0;
            c_user_q         <= 1'b0;
            m_tdata          <= '0;
            m_tvalid         <= 1'b0;
            m_tlast          <= 1'b0;
            m_tuser          <= 1'b0;
            fill_cnt_q       <= '0;
            frame_fill_count <= '0;
            frame_done       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (adv) begin
                m_tvalid <= emit;
                if (emit) begin
                    m_tdata <= fill_data;
                    m_tlast <= c_last_q;
                    m_tuser <= c_user_q;
                    // A frame start closes the previous frame's statistics.
                    if (c_user_q) begin
                        frame_fill_count <= fill_cnt_q;
                        frame_done       <= 1'b1;
                        fill_cnt_q       <= CW'(hit);
                    end else begin
                        fill_cnt_q <= cnt_inc;
                    end
                end

                case (state)
                    EMPTY: begin
                        if (accept) begin
                            c_q      <= s_tdata;
                            c_last_q <= s_tlast;
                            c_user_q <= s_tuser;
                            lv_q     <= 1'b0;
                            state    <= s_tlast ? FLUSH : HOLD;
                        end
                    end
                    HOLD: begin
                        if (early_sof) begin
                            state <= FLUSH;
                        end else if (accept) begin
                            l_q      <= c_q;
                            lv_q     <= 1'b1;
                            c_q      <= s_tdata;
                            c_last_q <= s_tlast;
                            c_user_q <= s_tuser;
                            state    <= s_tlast ? FLUSH : HOLD;
                        end
                    end
                    FLUSH: begin
                        lv_q  <= 1'b0;
                        state <= EMPTY;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_masked_pixel_fill.sv
// Directed bench for masked_pixel_fill: pixel fill values, framing, statistics,
// backpressure stability and mid-line reset.
module tb_masked_pixel_fill;

    localparam logic [15:0] FILL = 16'h00A5;
    localparam logic [15:0] MASK = 16'hFFFF;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] frame_fill_count;
    logic        frame_done;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    done_cnt = 0;
    int    mode     = 0;  // m_tready: 0 = high, 1 = random, 2 = low
    beat_t got[$];
    beat_t exp_q[$];

    masked_pixel_fill #(.DW(16), .FILL_VAL(FILL)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .frame_fill_count(frame_fill_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mode == 1) m_tready = 1'($urandom_range(0, 1));
            else           m_tready = (mode == 0);
        end
    end

    // Output monitor: capture transfers, count frame_done, check stall stability.
    initial begin
        logic  prev_stall = 1'b0;
        logic  prev_rst   = 1'b1;
        beat_t prev_beat  = '0;
        beat_t cur;
        forever begin
            @(negedge clk);
            cur.d = m_tdata; cur.l = m_tlast; cur.u = m_tuser;
            if (prev_stall && !prev_rst) begin
                chk("stall_valid", 32'(m_tvalid), 32'd1);
                chk("stall_beat", 32'(cur), 32'(prev_beat));
            end
            if (!rst && m_tvalid && m_tready) got.push_back(cur);
            if (!rst && frame_done) done_cnt++;
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = cur;
            prev_rst   = rst;
        end
    end

    task automatic send(input logic [15:0] d, input logic l, input logic u);
        bit ok = 1'b0;
        s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic ex(input logic [15:0] d, input logic l, input logic u);
        beat_t b;
        b.d = d; b.l = l; b.u = u;
        exp_q.push_back(b);
    endtask

    task automatic drain_check(input string tag);
        for (int k = 0; k < 3000 && got.size() < exp_q.size(); k++) @(negedge clk);
        @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] pix[4][64];
        logic [15:0] e;
        logic        lu, ru;
        int          idx;
        int          bp_masked = 0;

        rst = 1'b1; enable = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_outs", 32'({m_tdata, m_tlast, m_tuser}), 32'd0);
        chk("rst_stats", 32'({frame_fill_count, frame_done}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_s_tready", 32'(s_tready), 32'd1);

        // Clean line with latency and s_tready bubble checks
        send(16'd10, 1'b0, 1'b1);
        send(16'd20, 1'b0, 1'b0);
        chk("lat_first_valid", 32'(m_tvalid), 32'd1);
        chk("lat_first_data", 32'(m_tdata), 32'd10);
        chk("first_done", 32'(frame_done), 32'd1);
        send(16'd30, 1'b0, 1'b0);
        send(16'd40, 1'b1, 1'b0);
        chk("bubble_low", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1;
        chk("bubble_end", 32'(s_tready), 32'd1);
        ex(16'd10, 0, 1); ex(16'd20, 0, 0); ex(16'd30, 0, 0); ex(16'd40, 1, 0);
        drain_check("clean");

        // Interior fill
        send(16'd100, 1'b0, 1'b1);
        send(MASK, 1'b0, 1'b0);
        send(16'd201, 1'b1, 1'b0);
        ex(16'd100, 0, 1); ex(16'd150, 0, 0); ex(16'd201, 1, 0);
        drain_check("interior");

        // Edge / adjacent masks, all-masked line, 17-bit average
        send(MASK, 0, 1); send(16'd8, 0, 0); send(MASK, 0, 0); send(MASK, 0, 0); send(16'd6, 1, 0);
        ex(16'd8, 0, 1); ex(16'd8, 0, 0); ex(16'd8, 0, 0); ex(16'd6, 0, 0); ex(16'd6, 1, 0);
        send(MASK, 0, 0); send(MASK, 1, 0);
        ex(FILL, 0, 0); ex(FILL, 1, 0);
        send(16'hF000, 0, 0); send(MASK, 0, 0); send(16'hF002, 1, 0);
        ex(16'hF000, 0, 0); ex(16'hF001, 0, 0); ex(16'hF002, 1, 0);
        drain_check("edges");
        chk("count_interior_frame", 32'(frame_fill_count), 32'd1);

        // Bypass
        enable = 1'b0;
        send(MASK, 0, 1); send(16'd5, 1, 0);
        ex(MASK, 0, 1); ex(16'd5, 1, 0);
        drain_check("bypass");
        enable = 1'b1;
        chk("count_edges_frame", 32'(frame_fill_count), 32'd6);

        // Backpressure over a 64x4 frame against a reference of the fill rule
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 64; j++) begin
                idx = i * 64 + j;
                if ((idx % 5 == 2) || (idx % 13 == 0)) pix[i][j] = MASK;
                else pix[i][j] = 16'((idx * 2731) & 32'hFFFE);
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 64; j++) begin
                e = pix[i][j];
                if (pix[i][j] == MASK) begin
                    bp_masked++;
                    lu = 1'b0; ru = 1'b0;
                    if (j > 0)  lu = (pix[i][j-1] != MASK);
                    if (j < 63) ru = (pix[i][j+1] != MASK);
                    if (lu && ru)  e = 16'((32'(pix[i][j-1]) + 32'(pix[i][j+1])) / 2);
                    else if (lu)   e = pix[i][j-1];
                    else if (ru)   e = pix[i][j+1];
                    else           e = FILL;
                end
                ex(e, 1'(j == 63), 1'(i == 0 && j == 0));
            end
        mode = 1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 64; j++)
                send(pix[i][j], 1'(j == 63), 1'(i == 0 && j == 0));
        drain_check("backpressure");
        mode = 0;
        @(posedge clk);
        #1;
        chk("count_bypass_frame", 32'(frame_fill_count), 32'd0);

        // Early tuser while a line is held open
        send(16'd1, 0, 1);
        send(16'd2, 0, 0);
        chk("early_done_first", 32'(frame_done), 32'd1);
        chk("count_bp_frame", 32'(frame_fill_count), 32'(bp_masked));
        @(posedge clk);
        #1;
        done_cnt = 0;
        send(16'd3, 0, 0);
        send(16'd4, 1, 1);
        ex(16'd1, 0, 1); ex(16'd2, 0, 0); ex(16'd3, 0, 0); ex(16'd4, 1, 1);
        drain_check("early_sof");
        chk("early_done_pulses", 32'(done_cnt), 32'd1);
        chk("count_early_frame", 32'(frame_fill_count), 32'd0);

        // Reset mid-line with a stalled output beat pending
        mode = 2;
        @(posedge clk);
        #1;
        send(16'd7, 0, 1);
        send(16'd8, 0, 0);
        chk("stalled_pending", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_outs", 32'({m_tdata, m_tlast, m_tuser}), 32'd0);
        chk("midrst_stats", 32'({frame_fill_count, frame_done}), 32'd0);
        chk("midrst_s_tready", 32'(s_tready), 32'd0);
        rst = 1'b0;
        mode = 0;
        @(posedge clk);
        #1;
        chk("midrst_release", 32'(s_tready), 32'd1);

        // One-pixel lines after reset
        send(MASK, 1, 1);
        send(16'd9, 1, 0);
        ex(FILL, 1, 1); ex(16'd9, 1, 0);
        drain_check("one_pixel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
